// File: rtl/prf_freelist.sv
// Physical-register free list with committed map table: hands free physical IDs to
// rename and takes back registers released by commit or rollback bundles.
package prf_freelist_pkg;
  localparam int LRW = 5;
  localparam int PRW = 6;

  typedef struct packed {
    logic [15:0]    opid;
    logic [LRW-1:0] lrda;
    logic [PRW-1:0] prda;
    logic           rollback;
  } com_bundle_t;
endpackage

module prf_freelist
  import prf_freelist_pkg::*;
#(
  parameter int rwd   = 4,
  parameter int cwd   = 4,
  parameter int nlreg = 32,
  parameter int nphy  = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [rwd-1:0]                      alloc_req,
  output logic                                alloc_ok,
  output logic [rwd-1:0][$clog2(nphy)-1:0]    alloc_prda,
  input  com_bundle_t [cwd-1:0]               com_bundle,
  output logic [$clog2(nphy):0]               free_num,
  output logic                                err
);

  localparam int PW = $clog2(nphy);
  localparam int CW = PW + 1;
  localparam int INIT_FREE_I = nphy - nlreg;
  localparam int NPHY_M1_I   = nphy - 1;
  localparam logic [PW-1:0] INIT_TAIL = INIT_FREE_I[PW-1:0];
  localparam logic [CW-1:0] INIT_FREE = INIT_FREE_I[CW-1:0];
  localparam logic [CW:0]   NPHY_X    = nphy[CW:0];
  localparam logic [CW:0]   NPHY_M1   = NPHY_M1_I[CW:0];

  typedef logic [PW-1:0] preg_t;

  preg_t queue   [nphy];
  preg_t cmt_map [nlreg];
  preg_t head;
  preg_t tail;

  logic [CW-1:0]                 k;
  logic [rwd-1:0][CW-1:0]        aoff;
  logic [cwd-1:0]                cact;
  logic                          rb;
  preg_t                         old;
  logic [cwd-1:0][PW-1:0]        pval;
  logic [cwd-1:0]                pvld;
  logic [cwd-1:0][CW-1:0]        ppos;
  logic [CW-1:0]                 pcnt;
  logic [CW:0]                   fn_next;
  logic                          unused_bits;

  // Pointer advance is at most one lap short of nphy, so one conditional subtract wraps
  // correctly for non-power-of-2 queue depths as well.
  function automatic preg_t wrap_add(input preg_t a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s >= NPHY_X) s = s - NPHY_X;
    return s[PW-1:0];
  endfunction

  function automatic preg_t init_slot(input int i);
    int v;
    v = i + nlreg;
    return (i < INIT_FREE_I) ? v[PW-1:0] : '0;
  endfunction

  function automatic preg_t ident(input int i);
    return i[PW-1:0];
  endfunction

  always_comb begin
    k = '0;
    aoff = '0;
    for (int i = 0; i < rwd; i++) begin
      aoff[i] = k;
      if (alloc_req[i]) k = k + 1'b1;
    end
    alloc_ok = (free_num >= k);
    alloc_prda = '0;
    for (int i = 0; i < rwd; i++) alloc_prda[i] = queue[wrap_add(head, aoff[i])];
  end

  always_comb begin
    rb = com_bundle[0].rollback;
    cact = '0;
    for (int i = 0; i < cwd; i++) begin
      if (rb) cact[i] = (com_bundle[i].lrda != '0) && (com_bundle[i].prda != '0);
      else    cact[i] = com_bundle[i].opid[15] && (com_bundle[i].lrda != '0);
    end
  end

  // Within a commit bundle, an earlier lane to the same logical register supersedes
  // the committed map for later lanes, so its prda is what gets released.
  always_comb begin
    old = '0;
    pval = '0;
    pvld = '0;
    ppos = '0;
    pcnt = '0;
    for (int i = 0; i < cwd; i++) begin
      old = cmt_map[com_bundle[i].lrda];
      for (int j = 0; j < i; j++)
        if (cact[j] && (com_bundle[j].lrda == com_bundle[i].lrda)) old = com_bundle[j].prda;
      pval[i] = rb ? com_bundle[i].prda : old;
      pvld[i] = cact[i] && (pval[i] != '0);
      ppos[i] = pcnt;
      if (pvld[i]) pcnt = pcnt + 1'b1;
    end
  end

  always_comb begin
    fn_next = {1'b0, free_num} - (alloc_ok ? {1'b0, k} : '0) + {1'b0, pcnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < nlreg; i++) cmt_map[i] <= ident(i);
      for (int i = 0; i < nphy; i++)  queue[i]   <= init_slot(i);
      head     <= '0;
      tail     <= INIT_TAIL;
      free_num <= INIT_FREE;
      err      <= 1'b0;
    end else begin
      if (alloc_ok) head <= wrap_add(head, k);
      tail <= wrap_add(tail, pcnt);
      for (int i = 0; i < cwd; i++)
        if (pvld[i]) queue[wrap_add(tail, ppos[i])] <= pval[i];
      // Later lanes overwrite earlier ones, leaving the youngest writer in the map.
      if (!rb)
        for (int i = 0; i < cwd; i++)
          if (cact[i]) cmt_map[com_bundle[i].lrda] <= com_bundle[i].prda;
      free_num <= fn_next[CW-1:0];
      if (fn_next > NPHY_M1) err <= 1'b1;
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int i = 0; i < cwd; i++)
      unused_bits = unused_bits ^ (^com_bundle[i].opid[14:0]) ^ com_bundle[i].rollback;
  end

endmodule

// File: tb/tb_prf_freelist.sv
// Directed and model-checked random bench for the physical-register free list.
module tb_prf_freelist;
  import prf_freelist_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           alloc_req;
  logic                 alloc_ok;
  logic [3:0][5:0]      alloc_prda;
  com_bundle_t [3:0]    cb;
  logic [6:0]           free_num;
  logic                 err;

  int n_cmp = 0;
  int n_err = 0;

  int mq[$];
  int ip[$];
  int il[$];
  int mcmt[32];

  always #5 clk = ~clk;

  prf_freelist dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_prda(alloc_prda), .com_bundle(cb), .free_num(free_num), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    alloc_req = '0;
    cb = '0;
  endtask

  task automatic set_lane(input int i, input bit v, input int l, input int p, input bit r);
    cb[i].opid     = v ? 16'h8000 : 16'h0000;
    cb[i].lrda     = l[4:0];
    cb[i].prda     = p[5:0];
    cb[i].rollback = r;
  endtask

  initial begin
    int k, idx, n, exp_ok, old, p, l;
    bit rbm;
    int cp[4];
    int cl[4];

    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_free", 32'(free_num), 32);
    chk("rst_ok", 32'(alloc_ok), 1);
    chk("rst_err", 32'(err), 0);

    alloc_req = 4'b1011;
    #1;
    chk("a_ok", 32'(alloc_ok), 1);
    chk("a_l0", 32'(alloc_prda[0]), 32);
    chk("a_l1", 32'(alloc_prda[1]), 33);
    chk("a_l3", 32'(alloc_prda[3]), 34);
    tick();
    clr();
    #1;
    chk("a_free", 32'(free_num), 29);

    set_lane(0, 1, 5, 32, 0);
    tick();
    clr();
    #1;
    chk("b_free", 32'(free_num), 30);

    set_lane(0, 1, 7, 40, 0);
    set_lane(1, 1, 7, 41, 0);
    tick();
    clr();
    #1;
    chk("c_free", 32'(free_num), 32);

    set_lane(0, 0, 3, 45, 1);
    set_lane(1, 0, 0, 46, 1);
    set_lane(2, 0, 4, 0, 1);
    set_lane(3, 0, 6, 47, 1);
    tick();
    clr();
    #1;
    chk("d_free", 32'(free_num), 34);
    chk("d_err", 32'(err), 0);

    // Releases old mappings 32 (lrda 5), 41 (lrda 7), 3 (lrda 3 untouched by rollback).
    set_lane(0, 1, 5, 33, 0);
    set_lane(1, 1, 7, 42, 0);
    set_lane(2, 1, 3, 50, 0);
    set_lane(3, 0, 9, 51, 0);
    tick();
    clr();
    #1;
    chk("e_free", 32'(free_num), 37);

    alloc_req = 4'b1111;
    #1;
    chk("dr_l0", 32'(alloc_prda[0]), 35);
    chk("dr_l3", 32'(alloc_prda[3]), 38);
    tick();
    repeat (6) tick();
    clr();
    #1;
    chk("dr_free", 32'(free_num), 9);

    alloc_req = 4'b1111;
    #1;
    chk("q_l0", 32'(alloc_prda[0]), 63);
    chk("q_l1", 32'(alloc_prda[1]), 5);
    chk("q_l2", 32'(alloc_prda[2]), 7);
    chk("q_l3", 32'(alloc_prda[3]), 40);
    tick();
    alloc_req = 4'b0111;
    #1;
    chk("r_l0", 32'(alloc_prda[0]), 45);
    chk("r_l1", 32'(alloc_prda[1]), 47);
    chk("r_l2", 32'(alloc_prda[2]), 32);
    tick();
    clr();
    #1;
    chk("r_free", 32'(free_num), 2);

    alloc_req = 4'b0011;
    #1;
    chk("k_eq_free_ok", 32'(alloc_ok), 1);
    alloc_req = 4'b0111;
    set_lane(0, 1, 10, 60, 0);
    #1;
    chk("short_ok", 32'(alloc_ok), 0);
    tick();
    clr();
    #1;
    chk("short_free", 32'(free_num), 3);
    alloc_req = 4'b0111;
    #1;
    chk("retry_ok", 32'(alloc_ok), 1);
    chk("retry_l0", 32'(alloc_prda[0]), 41);
    chk("retry_l1", 32'(alloc_prda[1]), 3);
    chk("retry_l2", 32'(alloc_prda[2]), 10);
    tick();
    clr();
    #1;
    chk("empty_free", 32'(free_num), 0);
    alloc_req = 4'b0001;
    #1;
    chk("empty_ok", 32'(alloc_ok), 0);
    alloc_req = 4'b0000;
    #1;
    chk("empty_k0_ok", 32'(alloc_ok), 1);

    // Overflow: 8 rollback bundles of 4 push free_num from 32 to 64.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 0, 1, i + 1, 1);
      tick();
      if (c == 6) chk("ovf_pre_err", 32'(err), 0);
    end
    clr();
    #1;
    chk("ovf_err", 32'(err), 1);
    chk("ovf_free", 32'(free_num), 64);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ovf_rst_err", 32'(err), 0);

    mq = {};
    ip = {};
    il = {};
    for (int i = 32; i < 64; i++) mq.push_back(i);
    for (int i = 0; i < 32; i++) mcmt[i] = i;
    for (int c = 0; c < 200; c++) begin
      clr();
      alloc_req = 4'($urandom_range(0, 15));
      rbm = ($urandom_range(0, 7) == 0);
      n = $urandom_range(0, 4);
      if (n > ip.size()) n = ip.size();
      for (int j = 0; j < n; j++) begin
        cp[j] = ip.pop_front();
        cl[j] = il.pop_front();
        set_lane(j, rbm ? 1'($urandom_range(0, 1)) : 1'b1, cl[j], cp[j], rbm);
      end
      cb[0].rollback = rbm;
      #1;
      k = $countones(alloc_req);
      exp_ok = (mq.size() >= k) ? 1 : 0;
      chk("rnd_ok", 32'(alloc_ok), exp_ok);
      if (exp_ok == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) begin
          if (alloc_req[i]) begin
            chk("rnd_prda", 32'(alloc_prda[i]), mq[idx]);
            idx++;
          end
        end
        for (int i = 0; i < k; i++) begin
          p = mq.pop_front();
          l = $urandom_range(1, 31);
          ip.push_back(p);
          il.push_back(l);
        end
      end
      for (int j = 0; j < n; j++) begin
        if (rbm) mq.push_back(cp[j]);
        else begin
          old = mcmt[cl[j]];
          if (old != 0) mq.push_back(old);
          mcmt[cl[j]] = cp[j];
        end
      end
      tick();
      chk("rnd_free", 32'(free_num), mq.size());
    end
    chk("rnd_err", 32'(err), 0);

    alloc_req = 4'b1111;
    set_lane(0, 1, 2, 20, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    #1;
    chk("mid_rst_free", 32'(free_num), 32);
    chk("mid_rst_err", 32'(err), 0);
    alloc_req = 4'b1011;
    #1;
    chk("mid_rst_ok", 32'(alloc_ok), 1);
    chk("mid_rst_l0", 32'(alloc_prda[0]), 32);
    chk("mid_rst_l1", 32'(alloc_prda[1]), 33);
    chk("mid_rst_l3", 32'(alloc_prda[3]), 34);
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prf_freelist.md
# prf_freelist

Physical-register free list with committed (architectural) map table; consumes the commit bundle emitted by the ROB commit stage and supplies free physical register IDs to the rename stage. On normal commit it frees the physical register previously mapped to the committed logical destination; on rollback it frees the speculatively allocated register carried in each rollback lane. It sits between the rename stage (allocation side) and the commit stage (release side).

## Interface
Parameters:
- rwd, 4, rename lanes that may allocate per cycle
- cwd, 4, commit lanes per cycle
- nlreg, 32, logical registers; x0 is never renamed
- nphy, 64, physical registers; must satisfy nphy > nlreg; physical 0 is never allocated

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- alloc_req  in  rwd  lane i requests one physical register; any bit pattern is allowed
- alloc_ok  out  1  all requested lanes granted this cycle (all-or-nothing)
- alloc_prda  out  rwd x $clog2(nphy)  granted ID per lane; valid only when alloc_ok & alloc_req[i]
- com_bundle  in  com_bundle_t [cwd-1:0]  commit bundle; uses opid[15], lrda, prda, rollback
- free_num  out  $clog2(nphy)+1  entries currently in the free list
- err  out  1  sticky overflow/underflow flag, cleared only by rst

## Operation
- Storage: circular queue of nphy entries, head/tail pointers $clog2(nphy) bits (wrap modulo nphy), count free_num; commit map cmt_map[nlreg] of $clog2(nphy) bits.
- Reset: cmt_map[i]=i; queue slots 0..nphy-nlreg-1 hold nlreg..nphy-1; head=0, tail=nphy-nlreg, free_num=nphy-nlreg; alloc_ok follows combinationally; err=0.
- Allocation: k = popcount(alloc_req). alloc_ok = (free_num >= k). Lane i receives queue[head + number of requesting lanes below i]. When alloc_ok, head += k at the clock edge. When ~alloc_ok, nothing is popped and alloc_prda is don't-care. k=0 gives alloc_ok=1.
- Commit release (rollback bit of lane 0 = 0): lane i is active when opid[15]=1 and lrda!=0. old = cmt_map[lrda], unless a lower active lane j<i in the same bundle has the same lrda, in which case old = that nearest lane's prda. Push old; cmt_map[lrda] <= prda of the highest active lane writing that lrda.
- Rollback release (rollback=1): lane i is active when lrda!=0 and prda!=0, regardless of opid. Push prda. cmt_map is unchanged.
- Pushes are compacted in lane order at tail; tail += number of pushes.
- Simultaneous alloc and release: free_num_next = free_num - (alloc_ok ? k : 0) + pushes.
- Released IDs are not visible to allocation until the next cycle; there is no same-cycle bypass.
- Any ID equal to 0 is never pushed.
- err is set when free_num_next > nphy-1. State still updates with wrapped pointers; the condition is a protocol violation.

## Timing
- alloc_ok and alloc_prda are combinational from registered state (head, free_num, queue) and alloc_req; there is no dependence on com_bundle in the same cycle.
- Pops, pushes, and cmt_map updates take effect at the same posedge; a register freed at edge N can be allocated in the cycle following edge N.
- Reset mid-operation discards all in-flight state and restores the reset contents at the next edge.
- Full queue (free_num = nphy-nlreg after all speculation is drained) is the steady maximum. Empty queue: alloc_ok=0 for any k>0.
- Wrap-around: pointer arithmetic is modulo nphy for any nphy, including non-power-of-2 values, using explicit compare-and-subtract.

## Test plan
- Reset, then alloc_req=4'b1011 -> alloc_ok=1, prda lanes 0,1,3 = 32,33,34; next cycle free_num=29.
- Commit lrda=5, prda=32 after reset -> physical 5 is pushed, cmt_map[5]=32; free_num rises by 1 the next cycle.
- Same bundle: lane0 lrda=7/prda=40, lane1 lrda=7/prda=41 -> pushes 7 then 40; cmt_map[7]=41.
- Rollback bundle with lanes (3,45), (0,46), (4,0), (6,47) -> pushes only 45 and 47; cmt_map unchanged.
- Drain to free_num=2, request 3 -> alloc_ok=0 and head unchanged; the same cycle's commit push becomes visible next cycle, then request 3 -> alloc_ok=1.
- Run 200 random alloc/commit cycles with pointer wrap past nphy-1, then assert rst mid-stream -> outputs return to reset values; err stays 0 for legal traffic.
